// File: rtl/fifo_tx.sv
// fifo_tx: transmit byte FIFO and MSB-first bit serializer for the Zigbee baseband.
// APB writes push bytes into a DEPTH-entry circular buffer. While en_IQ is high,
// the FSM pops bytes and shifts them out, one bit every BIT_DIV clocks. IQ_rate
// marks the first cycle of every bit.
// Optional feature: define FIFO_TX_PSLVERR_EN to drive pslverr on a write while
// full and on a read attempt. Without it, pslverr is tied low.
module fifo_tx #(
  parameter int DEPTH   = 64,
  parameter int BIT_DIV = 25
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] pwdata,
  input  logic       psel,
  input  logic       pwrite,
  input  logic       penable,
  output logic       pready,
  output logic       pslverr,
  input  logic       en_IQ,
  output logic       data_out,
  output logic       IQ_rate,
  output logic       mem_state
);

  localparam int              AW       = $clog2(DEPTH);
  localparam int              DW       = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [AW:0]     FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [DW-1:0]   DIV_LAST = DW'(BIT_DIV - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_e;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  state_e        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [DW-1:0] div_q, div_d;

  logic full, empty, wr_req, push, pop;

  assign full   = (count_q == FULL_CNT);
  assign empty  = (count_q == '0);
  assign wr_req = psel & penable & pwrite;
  // A write while full is dropped, even when a pop happens in the same cycle.
  assign push   = wr_req & ~full;

  assign mem_state = full;
  assign pready    = ~full;
  assign data_out  = (state_q == S_SHIFT) & shift_q[bit_idx_q];
  assign IQ_rate   = (state_q == S_SHIFT) && (div_q == '0);

  // Storage array: written on accepted pushes only.
  // NOTE: the data array is deliberately not reset; the pointers and the count
  // define which entries are valid, and a reset on the array would prevent it
  // from being built as RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= pwdata;
  end

  // Serializer next state: load a byte, count the bit period, step bits MSB-first.
  always_comb begin
    // NOTE: every signal gets a default before the case statement, so no path
    // leaves a value unassigned and no latch is inferred.
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    div_d     = div_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en_IQ && !empty) begin
          pop       = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          bit_idx_d = 3'd7;
          div_d     = '0;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bit_idx_q != 3'd0) begin
            bit_idx_d = bit_idx_q - 3'd1;
          end else if (en_IQ && !empty) begin
            // Load the next byte with no gap, so the strobe period stays exact.
            pop       = 1'b1;
            shift_d   = mem_q[rd_ptr_q];
            bit_idx_d = 3'd7;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO bookkeeping: the pointers wrap naturally; the count sees push and pop together.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers: all cleared asynchronously, so any buffered data is lost on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      div_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples the values from
      // before this edge and the order of the statements does not matter.
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      div_q     <= div_d;
    end
  end

`ifdef FIFO_TX_PSLVERR_EN
  logic rd_req, pslverr_q, pslverr_d;

  assign rd_req = psel & penable & ~pwrite;

  // Error source: a write that hits a full FIFO, or any read attempt.
  always_comb pslverr_d = (wr_req & full) | rd_req;

  // Error register: the pulse appears in the cycle after the offending access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pslverr_q <= 1'b0;
    else          pslverr_q <= pslverr_d;
  end

  assign pslverr = pslverr_q;
`else
  assign pslverr = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_tx.sv
// tb_fifo_tx: scoreboard bench for fifo_tx. Expected bytes are queued as they
// are written and popped as the serialized bits are regrouped MSB-first.
module tb_fifo_tx;

  localparam int DEPTH   = 64;
  localparam int BIT_DIV = 25;
`ifdef FIFO_TX_PSLVERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] pwdata;
  logic       psel, pwrite, penable, en_IQ;
  logic       pready, pslverr, data_out, IQ_rate, mem_state;

  int         n_pass  = 0;
  int         n_total = 0;
  logic [7:0] exp_q[$];

  fifo_tx #(.DEPTH(DEPTH), .BIT_DIV(BIT_DIV)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .pwdata   (pwdata),
    .psel     (psel),
    .pwrite   (pwrite),
    .penable  (penable),
    .pready   (pready),
    .pslverr  (pslverr),
    .en_IQ    (en_IQ),
    .data_out (data_out),
    .IQ_rate  (IQ_rate),
    .mem_state(mem_state)
  );

  always #10 clk = ~clk;

  task automatic drive_write(input logic [7:0] v);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; pwdata = v;
  endtask

  task automatic drive_idle();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  // Watch the serial output until n_bytes are decoded, optionally feeding writes.
  task automatic serial_run(input string name, input int n_bytes, input int feed_base,
                            input int feed_n, input int exp_first);
    int first, last, min_gap, max_gap, pulses, got, nbit, it, extra, budget;
    logic [7:0] bits, exp_b;
    first = -1; last = -1; min_gap = 1 << 30; max_gap = 0;
    pulses = 0; got = 0; nbit = 0; it = 0; bits = '0; extra = 0;
    budget = n_bytes * 8 * BIT_DIV + 200;
    while (got < n_bytes && it < budget) begin
      @(negedge clk);
      if (IQ_rate) begin
        if (first < 0) first = it;
        else begin
          if (it - last < min_gap) min_gap = it - last;
          if (it - last > max_gap) max_gap = it - last;
        end
        last = it;
        pulses++;
        bits = {bits[6:0], data_out};
        nbit++;
        if (nbit == 8) begin
          nbit = 0;
          got++;
          n_total++;
          if (exp_q.size() == 0) begin
            $display("FAIL %s unexpected byte got=%02h exp=none", name, bits);
          end else begin
            exp_b = exp_q.pop_front();
            if (bits !== exp_b) $display("FAIL %s byte %0d got=%02h exp=%02h", name, got - 1, bits, exp_b);
            else n_pass++;
          end
        end
      end
      if (it < feed_n) begin
        drive_write(8'(feed_base + it));
        exp_q.push_back(8'(feed_base + it));
      end else begin
        drive_idle();
      end
      it++;
    end
    n_total++;
    if (got !== n_bytes) $display("FAIL %s bytes_received got=%0d exp=%0d", name, got, n_bytes);
    else n_pass++;
    n_total++;
    if (first !== exp_first) $display("FAIL %s first_strobe got=%0d exp=%0d", name, first, exp_first);
    else n_pass++;
    n_total++;
    if (pulses !== 8 * n_bytes) $display("FAIL %s pulse_count got=%0d exp=%0d", name, pulses, 8 * n_bytes);
    else n_pass++;
    n_total++;
    if (min_gap !== BIT_DIV || max_gap !== BIT_DIV)
      $display("FAIL %s strobe_gap got=%0d..%0d exp=%0d", name, min_gap, max_gap, BIT_DIV);
    else n_pass++;
    // FIFO must now be empty: no further strobes even with en_IQ still high.
    for (int k = 0; k < 3 * BIT_DIV; k++) begin
      @(negedge clk);
      if (IQ_rate) extra++;
    end
    n_total++;
    if (extra !== 0) $display("FAIL %s strobes_after_drain got=%0d exp=0", name, extra);
    else n_pass++;
    n_total++;
    if (exp_q.size() !== 0) $display("FAIL %s leftover_expected got=%0d exp=0", name, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; en_IQ = 1'b0; pwdata = '0;
    drive_idle();
    repeat (3) @(negedge clk);
    n_total++;
    if ({pready, pslverr, data_out, IQ_rate, mem_state} !== 5'b10000)
      $display("FAIL reset_outputs got=%05b exp=10000", {pready, pslverr, data_out, IQ_rate, mem_state});
    else n_pass++;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_total++;
    if ({pready, pslverr, IQ_rate, mem_state} !== 4'b1000)
      $display("FAIL post_reset_outputs got=%04b exp=1000", {pready, pslverr, IQ_rate, mem_state});
    else n_pass++;
  endtask

  task automatic test_fill();
    en_IQ = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      if (i == DEPTH - 1) begin
        n_total++;
        if (mem_state !== 1'b0 || pready !== 1'b1)
          $display("FAIL fill_almost_full got=%b/%b exp=0/1", mem_state, pready);
        else n_pass++;
      end
      drive_write(8'(i));
      exp_q.push_back(8'(i));
    end
    @(negedge clk);
    n_total++;
    if (mem_state !== 1'b1 || pready !== 1'b0)
      $display("FAIL fill_full got=%b/%b exp=1/0", mem_state, pready);
    else n_pass++;
  endtask

  task automatic test_overflow();
    // Signals still held from the fill: this is the 65th write, value 63.
    drive_write(8'd63);
    @(negedge clk);
    drive_idle();
    n_total++;
    if (pslverr !== EXP_ERR) $display("FAIL overflow_pslverr got=%b exp=%b", pslverr, EXP_ERR);
    else n_pass++;
    n_total++;
    if (mem_state !== 1'b1) $display("FAIL overflow_still_full got=%b exp=1", mem_state);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (pslverr !== 1'b0) $display("FAIL overflow_pulse_end got=%b exp=0", pslverr);
    else n_pass++;
  endtask

  task automatic test_drain();
    en_IQ = 1'b1;
    serial_run("drain", DEPTH, 0, 0, 0);
    n_total++;
    if (mem_state !== 1'b0 || pready !== 1'b1)
      $display("FAIL drain_flags got=%b/%b exp=0/1", mem_state, pready);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    // en_IQ stays high; writes 64..127 stream in while the serializer pops.
    serial_run("restart", DEPTH, 64, DEPTH, 2);
  endtask

  task automatic test_read_err();
    logic [7:0] vals [3];
    vals[0] = 8'hA5; vals[1] = 8'h3C; vals[2] = 8'hF0;
    @(negedge clk);
    en_IQ = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_write(vals[i]);
      exp_q.push_back(vals[i]);
    end
    @(negedge clk);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0;
    @(negedge clk);
    drive_idle();
    n_total++;
    if (pslverr !== EXP_ERR) $display("FAIL read_pslverr got=%b exp=%b", pslverr, EXP_ERR);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (pslverr !== 1'b0) $display("FAIL read_pulse_end got=%b exp=0", pslverr);
    else n_pass++;
    en_IQ = 1'b1;
    serial_run("read_unchanged", 3, 0, 0, 0);
  endtask

  task automatic test_async_reset();
    int extra;
    extra = 0;
    en_IQ = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      drive_write(8'hFF);
    end
    @(negedge clk);
    drive_idle();
    en_IQ = 1'b1;
    repeat (40) @(negedge clk);
    drive_write(8'hFF);
    @(negedge clk);
    drive_idle();
    n_total++;
    if (mem_state !== 1'b1 || data_out !== 1'b1)
      $display("FAIL pre_reset_state got=%b/%b exp=1/1", mem_state, data_out);
    else n_pass++;
    #3 reset_n = 1'b0;
    #1;
    n_total++;
    if ({data_out, IQ_rate, mem_state, pready} !== 4'b0001)
      $display("FAIL async_reset got=%04b exp=0001", {data_out, IQ_rate, mem_state, pready});
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 3 * BIT_DIV; k++) begin
      @(negedge clk);
      if (IQ_rate) extra++;
    end
    n_total++;
    if (extra !== 0) $display("FAIL data_lost_after_reset got=%0d exp=0", extra);
    else n_pass++;
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_back_to_back();
    test_read_err();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
